// File: rtl/ltpi_data_channel_controller.sv
// LTPI data-channel controller: arbitrates local requesters onto a single
// data channel, keeps one transaction outstanding, retags requests, and
// returns exactly one completion (real or synthesized) to the owner.

package ltpi_dc_pkg;
  localparam int TIMER_1MS_60MHZ = 60000;

  typedef enum logic [7:0] {
    READ_REQ   = 8'h00,
    WRITE_REQ  = 8'h01,
    READ_COMP  = 8'h02,
    WRITE_COMP = 8'h03,
    CRC_ERROR  = 8'h04
  } dc_command_e;

  typedef struct packed {
    dc_command_e command;
    logic [7:0]  tag;
    logic [31:0] address;
    logic [3:0]  byte_en;
    logic [31:0] data;
    logic        operation_status;
  } Data_channel_payload_t;
endpackage

module ltpi_data_channel_controller
  import ltpi_dc_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 10 * TIMER_1MS_60MHZ
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                data_channel_rst,
  input  logic                                link_operational,
  input  logic [NUM_REQ-1:0]                  rq_valid,
  input  Data_channel_payload_t [NUM_REQ-1:0] rq_payload,
  output logic [NUM_REQ-1:0]                  rq_ready,
  output Data_channel_payload_t               tx_payload,
  output logic                                tx_valid,
  input  logic                                tx_ack,
  input  Data_channel_payload_t               rx_payload,
  input  logic                                rx_valid,
  output Data_channel_payload_t               cpl_payload,
  output logic [NUM_REQ-1:0]                  cpl_valid,
  input  logic [NUM_REQ-1:0]                  cpl_ready,
  output logic                                busy,
  output logic [15:0]                         timeout_cnt,
  output logic [15:0]                         stale_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, CPL} state_e;

  state_e                state, state_nx;
  logic                  rst_any;
  logic [IDX_W-1:0]      last_grant, owner, grant_idx;
  logic                  grant_any;
  logic [7:0]            tag_cnt, orig_tag;
  logic [31:0]           timer;
  Data_channel_payload_t sel_req, err_cpl;
  dc_command_e           exp_cmd;
  logic                  accept, bad_cmd, in_flight, abort, rsp_match, timed_out;

  // Both resets have identical effect, so they share one asynchronous edge.
  assign rst_any = reset | data_channel_rst;

  // Round-robin search starting just after the last winner.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && rq_valid[(int'(last_grant) + 1 + k) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'((int'(last_grant) + 1 + k) % NUM_REQ);
      end
    end
  end

  assign sel_req   = rq_payload[grant_idx];
  assign bad_cmd   = (sel_req.command != READ_REQ) && (sel_req.command != WRITE_REQ);
  assign rq_ready  = (!rst_any && state == IDLE && link_operational && grant_any)
                     ? (NUM_REQ'(1) << grant_idx) : '0;
  assign accept    = |(rq_valid & rq_ready);
  assign in_flight = (state == SEND) || (state == WAIT);
  assign abort     = in_flight && !link_operational;
  assign tx_valid  = (state == SEND) && link_operational;
  assign exp_cmd   = (tx_payload.command == READ_REQ) ? READ_COMP : WRITE_COMP;
  assign rsp_match = (state == WAIT) && rx_valid && (rx_payload.tag == tx_payload.tag) &&
                     ((rx_payload.command == exp_cmd) || (rx_payload.command == CRC_ERROR));
  assign timed_out = in_flight && (timer == 32'(TIMEOUT_CYCLES - 1));
  assign cpl_valid = (state == CPL) ? (NUM_REQ'(1) << owner) : '0;
  assign busy      = (state != IDLE);

  // Error completion used for timeouts and link-loss aborts.
  always_comb begin
    err_cpl                  = '0;
    err_cpl.command          = exp_cmd;
    err_cpl.tag              = orig_tag;
    err_cpl.address          = tx_payload.address;
    err_cpl.byte_en          = tx_payload.byte_en;
    err_cpl.operation_status = 1'b1;
  end

  // Next-state selection; link loss beats everything, a match beats a timeout.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = bad_cmd ? CPL : SEND;
      SEND: if (abort) state_nx = CPL;
            else if (tx_ack) state_nx = WAIT;
            else if (timed_out) state_nx = CPL;
      WAIT: if (abort || rsp_match || timed_out) state_nx = CPL;
      CPL:  if (cpl_ready[owner]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst_any) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_any) state <= IDLE;
    else         state <= state_nx;
  end

  // Transaction datapath, timer and statistics counters.
  always_ff @(posedge clk or posedge rst_any) begin
    if (rst_any) begin
      tx_payload  <= '0;
      cpl_payload <= '0;
      owner       <= '0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      tag_cnt     <= '0;
      orig_tag    <= '0;
      timer       <= '0;
      timeout_cnt <= '0;
      stale_cnt   <= '0;
    end else begin
      if (state == IDLE && accept) begin
        tx_payload     <= sel_req;
        tx_payload.tag <= tag_cnt;
        orig_tag       <= sel_req.tag;
        owner          <= grant_idx;
        last_grant     <= grant_idx;
        tag_cnt        <= tag_cnt + 8'd1;
        timer          <= '0;
        if (bad_cmd) begin
          cpl_payload                  <= '0;
          cpl_payload.command          <= CRC_ERROR;
          cpl_payload.tag              <= sel_req.tag;
          cpl_payload.address          <= sel_req.address;
          cpl_payload.byte_en          <= sel_req.byte_en;
          cpl_payload.operation_status <= 1'b1;
        end
      end else if (in_flight) begin
        if (abort) begin
          cpl_payload <= err_cpl;
        end else if (state == SEND && tx_ack) begin
          timer <= '0;
        end else if (rsp_match) begin
          cpl_payload     <= rx_payload;
          cpl_payload.tag <= orig_tag;
        end else if (timed_out) begin
          cpl_payload <= err_cpl;
          if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
        end else begin
          timer <= timer + 32'd1;
        end
      end

      // A response is consumed only by a match that is not being aborted.
      if (rx_valid && !(rsp_match && !abort) && stale_cnt != 16'hFFFF)
        stale_cnt <= stale_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ltpi_data_channel_controller.sv
// Directed self-checking bench for ltpi_data_channel_controller.
module tb_ltpi_data_channel_controller;
  import ltpi_dc_pkg::*;

  localparam int NREQ = 2;
  localparam int TO   = 20;

  logic                             clk = 1'b0;
  logic                             reset, data_channel_rst, link_operational;
  logic [NREQ-1:0]                  rq_valid, rq_ready, cpl_valid, cpl_ready;
  Data_channel_payload_t [NREQ-1:0] rq_payload;
  Data_channel_payload_t            tx_payload, rx_payload, cpl_payload;
  logic                             tx_valid, tx_ack, rx_valid, busy;
  logic [15:0]                      timeout_cnt, stale_cnt;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] tag_model = 8'h00;
  logic [7:0] issued;
  int         n;

  ltpi_data_channel_controller #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .data_channel_rst(data_channel_rst),
    .link_operational(link_operational), .rq_valid(rq_valid),
    .rq_payload(rq_payload), .rq_ready(rq_ready), .tx_payload(tx_payload),
    .tx_valid(tx_valid), .tx_ack(tx_ack), .rx_payload(rx_payload),
    .rx_valid(rx_valid), .cpl_payload(cpl_payload), .cpl_valid(cpl_valid),
    .cpl_ready(cpl_ready), .busy(busy), .timeout_cnt(timeout_cnt),
    .stale_cnt(stale_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic Data_channel_payload_t mk(input dc_command_e cmd, input logic [7:0] tag,
                                               input logic [31:0] addr, input logic [3:0] be,
                                               input logic [31:0] data, input logic st);
    Data_channel_payload_t p;
    p = '{command: cmd, tag: tag, address: addr, byte_en: be, data: data, operation_status: st};
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full read: grant, issue, immediate ack, matching READ_COMP, completion.
  task automatic transact(input int owner_exp, input logic [7:0] orig,
                          input logic [31:0] data, input bit drop_valid);
    logic [7:0] t;
    #1;
    check("grant", rq_ready, 64'(1) << owner_exp);
    tick();
    if (drop_valid) rq_valid = '0;
    check("tx_valid", tx_valid, 1);
    check("tx_tag", tx_payload.tag, tag_model);
    t = tag_model;
    tag_model++;
    tx_ack = 1'b1;
    tick();
    tx_ack     = 1'b0;
    rx_valid   = 1'b1;
    rx_payload = mk(READ_COMP, t, 32'h0, 4'h0, data, 1'b0);
    tick();
    rx_valid = 1'b0;
    check("cpl_valid", cpl_valid, 64'(1) << owner_exp);
    check("cpl_tag", cpl_payload.tag, orig);
    check("cpl_data", cpl_payload.data, data);
    check("cpl_status", cpl_payload.operation_status, 0);
    cpl_ready = cpl_valid;
    tick();
    cpl_ready = '0;
  endtask

  initial begin
    reset = 1'b1; data_channel_rst = 1'b0; link_operational = 1'b1;
    rq_valid = 2'b11; rq_payload = '0; tx_ack = 1'b0;
    rx_valid = 1'b0; rx_payload = '0; cpl_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rq_ready", rq_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_cpl_valid", cpl_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_pl", tx_payload, 0);
    check("rst_cpl_pl", cpl_payload, 0);
    check("rst_counts", {timeout_cnt, stale_cnt}, 0);
    rq_valid = '0;
    reset = 1'b0;
    tick();

    // Alternating grants with continuous requests; issued tags 0..3.
    rq_payload[0] = mk(READ_REQ, 8'h10, 32'h100, 4'hF, 32'h0, 1'b0);
    rq_payload[1] = mk(READ_REQ, 8'h20, 32'h200, 4'hF, 32'h0, 1'b0);
    rq_valid = 2'b11;
    transact(0, 8'h10, 32'h1111_0000, 1'b0);
    transact(1, 8'h20, 32'h2222_0001, 1'b0);
    transact(0, 8'h10, 32'h3333_0002, 1'b0);
    transact(1, 8'h20, 32'h4444_0003, 1'b1);

    // Requester 1 read with tag 0x5A.
    rq_payload[1] = mk(READ_REQ, 8'h5A, 32'h300, 4'hF, 32'h0, 1'b0);
    rq_valid = 2'b10;
    transact(1, 8'h5A, 32'hDEAD_BEEF, 1'b1);

    // Write with no response: synthesized WRITE_COMP after TIMEOUT cycles.
    rq_payload[0] = mk(WRITE_REQ, 8'h33, 32'h1000, 4'h3, 32'h1234, 1'b0);
    rq_valid = 2'b01;
    tick();
    rq_valid = '0;
    tag_model++;
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    n = 0;
    while (cpl_valid == 0 && n < TO + 10) begin
      tick();
      n++;
    end
    check("to_latency", n, TO);
    check("to_cmd", cpl_payload.command, WRITE_COMP);
    check("to_status", cpl_payload.operation_status, 1);
    check("to_data", cpl_payload.data, 0);
    check("to_tag", cpl_payload.tag, 8'h33);
    check("to_addr", cpl_payload.address, 32'h1000);
    check("to_be", cpl_payload.byte_en, 4'h3);
    check("to_cnt", timeout_cnt, 1);
    tick();
    tick();
    check("cpl_hold", cpl_valid, 2'b01);
    cpl_ready = 2'b01;
    tick();
    cpl_ready = '0;
    check("to_idle", busy, 0);

    // Wrong tag is dropped as stale; the correct one completes.
    rq_payload[1] = mk(READ_REQ, 8'h77, 32'h400, 4'hF, 32'h0, 1'b0);
    rq_valid = 2'b10;
    tick();
    rq_valid = '0;
    issued = tag_model;
    tag_model++;
    tx_ack = 1'b1;
    tick();
    tx_ack     = 1'b0;
    rx_valid   = 1'b1;
    rx_payload = mk(READ_COMP, issued + 8'd1, 32'h0, 4'h0, 32'hBAD0_BAD0, 1'b0);
    tick();
    check("stale_busy", cpl_valid, 0);
    rx_payload = mk(READ_COMP, issued, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    tick();
    rx_valid = 1'b0;
    check("stale_cnt1", stale_cnt, 1);
    check("stale_cpl_v", cpl_valid, 2'b10);
    check("stale_cpl_d", cpl_payload.data, 32'hCAFE_F00D);
    check("stale_cpl_t", cpl_payload.tag, 8'h77);
    cpl_ready = 2'b10;
    tick();
    cpl_ready = '0;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("stale_idle", stale_cnt, 2);

    // Unsupported command goes straight to a CRC_ERROR completion.
    rq_payload[0] = mk(dc_command_e'(8'h07), 8'h11, 32'h500, 4'hF, 32'h99, 1'b0);
    rq_valid = 2'b01;
    tick();
    rq_valid = '0;
    tag_model++;
    check("bad_tx", tx_valid, 0);
    check("bad_cpl_v", cpl_valid, 2'b01);
    check("bad_cmd", cpl_payload.command, CRC_ERROR);
    check("bad_status", cpl_payload.operation_status, 1);
    check("bad_data", cpl_payload.data, 0);
    cpl_ready = 2'b01;
    tick();
    cpl_ready = '0;

    // Link drop in WAIT aborts; no grants until the link returns.
    rq_payload[1] = mk(READ_REQ, 8'h42, 32'h2000, 4'hF, 32'h0, 1'b0);
    rq_valid = 2'b10;
    tick();
    rq_valid = '0;
    tag_model++;
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    link_operational = 1'b0;
    tick();
    check("ld_cpl_v", cpl_valid, 2'b10);
    check("ld_cmd", cpl_payload.command, READ_COMP);
    check("ld_status", cpl_payload.operation_status, 1);
    check("ld_addr", cpl_payload.address, 32'h2000);
    check("ld_to_cnt", timeout_cnt, 1);
    rq_valid = 2'b01;
    #1;
    check("ld_rdy_cpl", rq_ready, 0);
    cpl_ready = 2'b10;
    tick();
    cpl_ready = '0;
    check("ld_rdy_idle", rq_ready, 0);
    tick();
    check("ld_rdy_idle2", rq_ready, 0);
    rq_payload[0] = mk(READ_REQ, 8'h99, 32'h600, 4'hF, 32'h0, 1'b0);
    link_operational = 1'b1;
    #1;
    check("ld_rdy_back", rq_ready, 2'b01);

    // Data-channel reset mid-transaction: no completion, tags restart at 0.
    tick();
    rq_valid = '0;
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    data_channel_rst = 1'b1;
    #2;
    check("dr_busy", busy, 0);
    check("dr_tx_pl", tx_payload, 0);
    data_channel_rst = 1'b0;
    tag_model = 8'h00;
    n = 0;
    repeat (TO + 4) begin
      tick();
      if (cpl_valid != 0) n++;
    end
    check("dr_no_cpl", n, 0);
    check("dr_counts", {timeout_cnt, stale_cnt}, 0);
    rq_payload[1] = mk(READ_REQ, 8'h3C, 32'h700, 4'hF, 32'h0, 1'b0);
    rq_valid = 2'b10;
    transact(1, 8'h3C, 32'h0BAD_CAFE, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion of test sequence");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ltpi_data_channel_controller.md
LTPI_DATA_CHANNEL_CONTROLLER -- requirements
Module: ltpi_data_channel_controller

Interface
REQ-001 Parameter NUM_REQ, default 2, number of local requesters sharing the data channel (2..4).
REQ-002 Parameter TIMEOUT_CYCLES, default 10*TIMER_1MS_60MHZ, clk cycles to wait for a completion before synthesizing an error.
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- data_channel_rst  in  1  asynchronous, active-high; same effect as reset.
- link_operational  in  1  high when local_link_state == operational_st.
- rq_valid  in  NUM_REQ  requester i has a request pending.
- rq_payload  in  NUM_REQ x Data_channel_payload_t  request from requester i.
- rq_ready  out  NUM_REQ  one-hot; the request is accepted on the cycle rq_valid[i] & rq_ready[i].
- tx_payload  out  Data_channel_payload_t  request toward the remote target.
- tx_valid  out  1  request valid; held until tx_ack.
- tx_ack  in  1  the channel has consumed tx_payload.
- rx_payload  in  Data_channel_payload_t  response from the remote target.
- rx_valid  in  1  single-cycle response strobe.
- cpl_payload  out  Data_channel_payload_t  completion returned to the owning requester.
- cpl_valid  out  NUM_REQ  one-hot completion valid; held until the matching cpl_ready bit.
- cpl_ready  in  NUM_REQ  the requester consumes the completion.
- busy  out  1  a transaction is in flight (state != IDLE).
- timeout_cnt  out  16  count of timeouts; saturates at 16'hFFFF.
- stale_cnt  out  16  count of dropped rx responses; saturates.

Function
REQ-004 The FSM shall use four states: IDLE, SEND, WAIT and CPL, with exactly one transaction outstanding at a time.
REQ-005 In IDLE, when link_operational=1 and any rq_valid bit is set, rq_ready shall combinationally assert on the round-robin winner only.
- Search starts at index last_grant+1 mod NUM_REQ.
- last_grant resets to NUM_REQ-1, so requester 0 wins first.
REQ-006 On acceptance, the block shall:
- capture the payload and the owner index;
- save the requester's original tag;
- replace the tag with the internal tag counter value;
- increment the tag counter, which has the tag-field width and wraps to 0;
- update last_grant;
- go to SEND.
REQ-007 rq_ready shall be 0 in every state other than IDLE, and 0 whenever link_operational=0.
REQ-008 A captured command other than READ_REQ or WRITE_REQ shall skip SEND/WAIT and go directly to CPL.
- The completion carries operation_status=1, data=0 and command=CRC_ERROR.
REQ-009 In SEND, tx_valid=1 with a stable tx_payload; tx_ack shall move the FSM to WAIT and clear the timer.
- tx_valid is therefore high from the cycle after acceptance.
REQ-010 In WAIT, a response shall match when rx_valid=1, rx tag equals the issued tag, and the command is the expected completion or CRC_ERROR.
- Expected completion is READ_COMP for READ_REQ and WRITE_COMP for WRITE_REQ.
- A match shall capture rx_payload into cpl_payload (tag restored to the original) and go to CPL.
REQ-011 Any rx_valid that does not match in WAIT, or that arrives in any other state, shall be dropped and increment stale_cnt.
REQ-012 The timer shall count clk cycles in SEND and WAIT.
- On reaching TIMEOUT_CYCLES-1 without a match, the block shall go to CPL.
- The completion carries the expected completion command, the original tag, the request address and byte_en, operation_status=1 and data=0.
- timeout_cnt shall increment.
REQ-013 link_operational falling while in SEND or WAIT shall abort to CPL with the REQ-012 error completion.
- tx_valid drops the same cycle; timeout_cnt is not incremented.
REQ-014 A match and a timeout in the same cycle shall resolve in favour of the match.
REQ-015 In CPL, cpl_valid[owner]=1; the matching cpl_ready bit shall return the FSM to IDLE the next cycle.
- Completions are never dropped for lack of cpl_ready.
REQ-016 The minimum request-to-completion cycle shall be:
- T0 accept;
- T1 tx_valid;
- tx_ack at T1 moves the FSM to WAIT at T2;
- rx match at T2 gives cpl_valid at T3.

Reset
REQ-017 When reset or data_channel_rst is asserted, the block shall:
- enter IDLE;
- drive rq_ready=0, tx_valid=0 and cpl_valid=0;
- clear tx_payload and cpl_payload to '0;
- clear the tag counter, timeout_cnt, stale_cnt and the timer;
- set last_grant to NUM_REQ-1.
REQ-018 A reset asserted mid-transaction shall discard the transaction without issuing a completion.

Verification
REQ-019 rq_valid=2'b11 held continuously, with immediate tx_ack and a matching rx -> grants alternate 0,1,0,1 and issued tags are 0,1,2,3.
REQ-020 Requester 1 sends READ_REQ with tag 0x5A; rx READ_COMP with issued tag and data 0xDEADBEEF -> cpl_valid=2'b10, tag 0x5A, data 0xDEADBEEF, status 0.
REQ-021 WRITE_REQ with no rx response -> after TIMEOUT_CYCLES, completion is WRITE_COMP with status=1 and data=0, and timeout_cnt=1.
REQ-022 rx with a wrong tag during WAIT, then the correct tag -> stale_cnt=1 and the completion carries the correct response.
REQ-023 link_operational deasserted during WAIT -> error completion next cycle, rq_ready held at 0 until the link returns.
REQ-024 data_channel_rst pulsed in WAIT, then a new request -> no completion for the old request, and the new request is issued with tag 0.
